// File: rtl/wb_scheduler_if.sv
// Decode-issue, ALU/long-unit writeback and register-file write signals around wb_scheduler.
interface wb_scheduler_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   logic            issue_valid;
   logic [4:0]      issue_rs1;
   logic [4:0]      issue_rs2;
   logic [4:0]      issue_rd;
   logic            issue_wr;
   logic            issue_long;
   logic            stall;
   logic            a_valid;
   logic [4:0]      a_rd;
   logic [XLEN-1:0] a_data;
   logic            b_valid;
   logic            b_ready;
   logic [4:0]      b_rd;
   logic [XLEN-1:0] b_data;
   logic [4:0]      rd;
   logic [XLEN-1:0] wdata;
   logic            regwrite;
   logic [NREG-1:0] busy;
   logic            err;

   modport master (
      output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr, issue_long,
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      input  stall, b_ready, rd, wdata, regwrite, busy, err
   );

   modport slave (
      input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr, issue_long,
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
      output stall, b_ready, rd, wdata, regwrite, busy, err
   );
endinterface

// File: rtl/wb_scheduler.sv
// Shares the register-file write port between ALU (priority) and long unit, scoreboards pending
// long writes and stalls decode on RAW/WAW or when MAXOUT long ops are outstanding; 1-cycle write latency.
module wb_scheduler #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int MAXOUT = 4
) (
   input  logic          clk,
   input  logic          rst,
   wb_scheduler_if.slave bus
);
   localparam int CW = $clog2(MAXOUT + 1);

   logic [NREG-1:0] busy_q, busy_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            regwrite_q, regwrite_d;
   logic            src_b_q, src_b_d;
   logic            err_q, err_d;

   logic            stall_c;
   logic            b_ready_c;
   logic            issue_ok;
   logic            long_ok;
   logic            b_hs;

   always_comb begin
      stall_c   = bus.issue_valid &
                  (busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] |
                   (bus.issue_wr & busy_q[bus.issue_rd]) |
                   (bus.issue_long & (cnt_q == CW'(MAXOUT))));
      b_ready_c = ~bus.a_valid & (cnt_q != '0);
      issue_ok  = bus.issue_valid & ~stall_c;
      long_ok   = issue_ok & bus.issue_long;
      b_hs      = bus.b_valid & b_ready_c;
   end

   always_comb begin
      busy_d = busy_q;
      // The write that retires a long op commits this edge, so its dependents may issue next cycle.
      if (regwrite_q & src_b_q) begin
         busy_d[rd_q] = 1'b0;
      end
      if (long_ok & bus.issue_wr & (bus.issue_rd != 5'd0)) begin
         busy_d[bus.issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;

      cnt_d = cnt_q;
      if (long_ok & ~b_hs) begin
         cnt_d = cnt_q + CW'(1);
      end else if (b_hs & ~long_ok) begin
         cnt_d = cnt_q - CW'(1);
      end

      rd_d       = rd_q;
      wdata_d    = wdata_q;
      regwrite_d = 1'b0;
      src_b_d    = 1'b0;
      if (bus.a_valid) begin
         rd_d       = bus.a_rd;
         wdata_d    = bus.a_data;
         regwrite_d = (bus.a_rd != 5'd0);
      end else if (b_hs) begin
         rd_d       = bus.b_rd;
         wdata_d    = bus.b_data;
         regwrite_d = (bus.b_rd != 5'd0);
         src_b_d    = 1'b1;
      end

      err_d = err_q |
              (b_hs & (bus.b_rd != 5'd0) & ~busy_q[bus.b_rd]) |
              (bus.b_valid & (cnt_q == '0)) |
              (bus.a_valid & (bus.a_rd != 5'd0) & busy_q[bus.a_rd]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         cnt_q      <= '0;
         rd_q       <= 5'd0;
         wdata_q    <= '0;
         regwrite_q <= 1'b0;
         src_b_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wdata_q    <= wdata_d;
         regwrite_q <= regwrite_d;
         src_b_q    <= src_b_d;
         err_q      <= err_d;
      end
   end

   assign bus.stall    = stall_c;
   assign bus.b_ready  = b_ready_c;
   assign bus.rd       = rd_q;
   assign bus.wdata    = wdata_q;
   assign bus.regwrite = regwrite_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_wb_scheduler.sv
// Random decode/ALU/long-unit traffic against a per-cycle reference model, then directed scenarios.
module tb_wb_scheduler;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int MAXOUT = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [NREG-1:0] m_busy;
   int              m_cnt;
   logic            m_rw, m_srcb, m_err;
   logic [4:0]      m_rd;
   logic [XLEN-1:0] m_wd;
   int              q_long[$];
   bit              t_iok, t_bhs;

   always #5 clk = ~clk;

   wb_scheduler_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   wb_scheduler #(.XLEN(XLEN), .NREG(NREG), .MAXOUT(MAXOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_stall();
      return bus.issue_valid && (m_busy[bus.issue_rs1] || m_busy[bus.issue_rs2] ||
             (bus.issue_wr && m_busy[bus.issue_rd]) || (bus.issue_long && m_cnt == MAXOUT));
   endfunction

   function automatic logic exp_bready();
      return !bus.a_valid && m_cnt != 0;
   endfunction

   task automatic model_reset();
      m_busy = '0; m_cnt = 0; m_rw = 1'b0; m_srcb = 1'b0; m_err = 1'b0;
      m_rd = 5'd0; m_wd = '0;
      q_long.delete();
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0; bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0; bus.issue_rd = 5'd0;
      bus.issue_wr = 1'b0; bus.issue_long = 1'b0;
      bus.a_valid = 1'b0; bus.a_rd = 5'd0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_rd = 5'd0; bus.b_data = '0;
   endtask

   // One clock: compare all outputs at negedge, then advance the model across the rising edge.
   task automatic tick();
      logic [NREG-1:0] nb;
      @(negedge clk);
      check("stall", bus.stall, exp_stall());
      check("b_ready", bus.b_ready, exp_bready());
      check("regwrite", bus.regwrite, m_rw);
      check("rd", bus.rd, m_rd);
      check("wdata", bus.wdata, m_wd);
      check("busy", bus.busy, m_busy);
      check("err", bus.err, m_err);
      t_iok = bus.issue_valid && !exp_stall();
      t_bhs = bus.b_valid && exp_bready();
      @(posedge clk);
      nb = m_busy;
      if (m_rw && m_srcb) nb[m_rd] = 1'b0;
      if (t_iok && bus.issue_long && bus.issue_wr && bus.issue_rd != 5'd0) nb[bus.issue_rd] = 1'b1;
      if (t_bhs && bus.b_rd != 5'd0 && !m_busy[bus.b_rd]) m_err = 1'b1;
      if (bus.b_valid && m_cnt == 0) m_err = 1'b1;
      if (bus.a_valid && bus.a_rd != 5'd0 && m_busy[bus.a_rd]) m_err = 1'b1;
      if (bus.a_valid) begin
         m_rd = bus.a_rd; m_wd = bus.a_data; m_rw = (bus.a_rd != 5'd0); m_srcb = 1'b0;
      end else if (t_bhs) begin
         m_rd = bus.b_rd; m_wd = bus.b_data; m_rw = (bus.b_rd != 5'd0); m_srcb = 1'b1;
      end else begin
         m_rw = 1'b0; m_srcb = 1'b0;
      end
      m_cnt = m_cnt + ((t_iok && bus.issue_long) ? 1 : 0) - (t_bhs ? 1 : 0);
      if (t_bhs && q_long.size() > 0) void'(q_long.pop_front());
      if (t_iok && bus.issue_long) q_long.push_back(bus.issue_wr ? int'(bus.issue_rd) : 0);
      m_busy = nb;
      #1;
   endtask

   // Legal traffic: decode holds stalled instructions, ALU avoids pending regs, long unit returns in order.
   task automatic drive_random(input bit quiet);
      if (quiet) begin
         bus.issue_valid = 1'b0;
      end else if (!(bus.issue_valid && !t_iok)) begin
         bus.issue_valid = ($urandom_range(0, 2) != 0);
         bus.issue_rs1   = 5'($urandom_range(0, 7));
         bus.issue_rs2   = 5'($urandom_range(0, 7));
         bus.issue_rd    = 5'($urandom_range(0, 7));
         bus.issue_wr    = ($urandom_range(0, 3) != 0);
         bus.issue_long  = ($urandom_range(0, 2) == 0);
      end
      bus.a_valid = !quiet && ($urandom_range(0, 2) == 0);
      bus.a_rd    = 5'($urandom_range(0, 7));
      if (m_busy[bus.a_rd]) bus.a_rd = 5'd0;
      bus.a_data  = $urandom;
      if (!(bus.b_valid && !t_bhs)) begin
         if (q_long.size() > 0 && $urandom_range(0, 1) == 1) begin
            bus.b_valid = 1'b1;
            bus.b_rd    = 5'(q_long[0]);
            bus.b_data  = $urandom;
         end else begin
            bus.b_valid = 1'b0;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      #2;
      check("rst_busy", bus.busy, 0);
      check("rst_regwrite", bus.regwrite, 0);
      check("rst_rd", bus.rd, 0);
      check("rst_wdata", bus.wdata, 0);
      check("rst_err", bus.err, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_bready", bus.b_ready, 0);
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 600; i++) begin
         drive_random(1'b0);
         tick();
      end
      for (int i = 0; i < 300 && (q_long.size() > 0 || bus.b_valid); i++) begin
         drive_random(1'b1);
         tick();
      end
      idle();
      tick();
      #1;
      check("rand_err", bus.err, 0);
      check("drain_bready", bus.b_ready, 0);

      // Long issue to x5, dependent stalls until the writeback has committed.
      bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd5;
      tick();
      idle();
      #1 check("busy5_set", bus.busy[5], 1);
      bus.issue_valid = 1'b1; bus.issue_rs1 = 5'd5;
      #1 check("raw_stall", bus.stall, 1);
      bus.b_valid = 1'b1; bus.b_rd = 5'd5; bus.b_data = 32'hDEADBEEF;
      #1 check("b5_ready", bus.b_ready, 1);
      tick();
      bus.b_valid = 1'b0;
      #1;
      check("wb5_regwrite", bus.regwrite, 1);
      check("wb5_rd", bus.rd, 5);
      check("wb5_wdata", bus.wdata, 32'hDEADBEEF);
      check("wb5_stall", bus.stall, 1);
      tick();
      #1;
      check("busy5_clr", bus.busy[5], 0);
      check("dep_stall", bus.stall, 0);
      tick();
      idle();

      // Same-cycle A and B: A wins, B follows next cycle.
      bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd7;
      tick();
      idle();
      bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h11;
      bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'h77;
      #1 check("cont_bready0", bus.b_ready, 0);
      tick();
      bus.a_valid = 1'b0;
      #1;
      check("cont_a_regwrite", bus.regwrite, 1);
      check("cont_a_rd", bus.rd, 3);
      check("cont_a_wdata", bus.wdata, 32'h11);
      check("cont_bready1", bus.b_ready, 1);
      tick();
      bus.b_valid = 1'b0;
      #1;
      check("cont_b_regwrite", bus.regwrite, 1);
      check("cont_b_rd", bus.rd, 7);
      check("cont_b_wdata", bus.wdata, 32'h77);
      tick();
      tick();

      // Outstanding limit with x0 destinations.
      bus.issue_valid = 1'b1; bus.issue_long = 1'b1;
      for (int i = 0; i < MAXOUT; i++) tick();
      #1 check("full_stall", bus.stall, 1);
      tick();
      bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h5A5A;
      #1;
      check("full_stall_hs", bus.stall, 1);
      check("full_bready", bus.b_ready, 1);
      tick();
      bus.b_valid = 1'b0;
      #1 check("full_accept", bus.stall, 0);
      tick();
      bus.issue_valid = 1'b0;
      bus.b_valid = 1'b1;
      for (int i = 0; i < MAXOUT; i++) tick();
      bus.b_valid = 1'b0;
      #1;
      check("x0_regwrite", bus.regwrite, 0);
      check("x0_busy", bus.busy, 0);
      check("x0_err", bus.err, 0);
      check("x0_cnt_zero", bus.b_ready, 0);
      tick();

      // Long-unit writeback to a register nobody is waiting for.
      bus.issue_valid = 1'b1; bus.issue_long = 1'b1;
      tick();
      idle();
      bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h99;
      tick();
      bus.b_valid = 1'b0;
      #1 check("err_b9", bus.err, 1);
      tick();
      #1 check("err_sticky", bus.err, 1);

      // Asynchronous reset with x4 pending and two ops outstanding.
      bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_wr = 1'b1; bus.issue_rd = 5'd4;
      tick();
      bus.issue_wr = 1'b0; bus.issue_rd = 5'd0;
      bus.a_valid = 1'b1; bus.a_rd = 5'd2; bus.a_data = 32'h22;
      tick();
      idle();
      #1;
      check("pre_rst_busy", bus.busy, 32'h10);
      check("pre_rst_regwrite", bus.regwrite, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_regwrite", bus.regwrite, 0);
      check("mid_rst_err", bus.err, 0);
      check("mid_rst_cnt", bus.b_ready, 0);
      rst = 1'b0;
      model_reset();
      tick();

      // B beat with nothing outstanding.
      bus.b_valid = 1'b1; bus.b_rd = 5'd0;
      #1 check("cnt0_bready", bus.b_ready, 0);
      tick();
      bus.b_valid = 1'b0;
      #1 check("err_cnt0", bus.err, 1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
